deser_4b: RTL and testbench

//   Serial-to-parallel front end for the Reg_4b datapath register.

---
 rtl/deser_4b.sv | 107 ++++++++++
 tb/tb_deser_4b.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/deser_4b.sv
// deser_4b: serial-to-parallel front end for the Reg_4b datapath register.
// Collects a start-framed serial bit stream into an NBITS-wide word and
// pulses out_en for one cycle when the word is complete. A start seen
// mid-frame restarts collection and pulses abort. All outputs are either
// registered or decoded from state, so there is no combinational path
// from the inputs to the outputs.
module deser_4b #(
    parameter int NBITS     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_val,
    input  logic             bit_in,
    output logic             out_en,
    output logic [NBITS-1:0] out_data,
    output logic             busy,
    output logic             abort
);

    localparam int            CW   = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_shift;
    logic             last_bit;

    // Next shift-register value; bit order is fixed at elaboration time.
    always_comb begin
        if (MSB_FIRST)
            shreg_shift = {shreg[NBITS-2:0], bit_in};
        else
            shreg_shift = {bit_in, shreg[NBITS-1:1]};
    end

    // The frame's final bit; a simultaneous start wins and restarts instead.
    assign last_bit = (state == SHIFT) && !start && bit_val && (count == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (start) state_nxt = SHIFT;
                     else if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bit counter, shift register, captured word and abort pulse.
    // out_data only ever loads a fully shifted word, so partial frames never
    // become visible downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            shreg    <= '0;
            out_data <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                SHIFT: begin
                    if (start) begin
                        count <= '0;
                        shreg <= '0;
                        abort <= 1'b1;
                    end else if (bit_val) begin
                        shreg <= shreg_shift;
                        if (count == LAST) begin
                            out_data <= shreg_shift;
                            count    <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE ignore bit_val; start opens a clean frame.
                    if (start) begin
                        count <= '0;
                        shreg <= '0;
                    end
                end
            endcase
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        out_en = (state == DONE);
        busy   = (state == SHIFT);
    end

endmodule

// File: tb/tb_deser_4b.sv
// Directed self-checking bench for deser_4b. An MSB-first and an LSB-first
// instance share the same stimulus; a small register model stands in for
// Reg_4b, capturing out_data whenever out_en is high.
module tb_deser_4b;

    logic       clk = 1'b0;
    logic       reset, start, bit_val, bit_in;
    logic       en_m, busy_m, abort_m, en_l, busy_l, abort_l;
    logic [3:0] data_m, data_l, q;

    int nchk = 0;
    int errs = 0;
    int cyc = 0, en_cnt = 0, abort_cnt = 0, en_t_last = 0, en_t_prev = 0;

    always #5 clk = ~clk;

    deser_4b #(.NBITS(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .start(start), .bit_val(bit_val), .bit_in(bit_in),
        .out_en(en_m), .out_data(data_m), .busy(busy_m), .abort(abort_m));

    deser_4b #(.NBITS(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .bit_val(bit_val), .bit_in(bit_in),
        .out_en(en_l), .out_data(data_l), .busy(busy_l), .abort(abort_l));

    // Reg_4b model: en/d driven by out_en/out_data.
    always @(posedge clk) begin
        if (reset)     q <= 4'h0;
        else if (en_m) q <= data_m;
    end

    // Pulse monitors.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (en_m) begin
            en_cnt    = en_cnt + 1;
            en_t_prev = en_t_last;
            en_t_last = cyc;
        end
        if (abort_m) abort_cnt = abort_cnt + 1;
    end

    // Apply one cycle of inputs and sample 1 ns after the edge.
    task automatic drive(input logic s, input logic v, input logic b);
        start = s; bit_val = v; bit_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        nchk++; if (data_m !== 4'h0) begin errs++; $display("FAIL reset_data_m actual=%h expected=0", data_m); end
        nchk++; if (data_l !== 4'h0) begin errs++; $display("FAIL reset_data_l actual=%h expected=0", data_l); end
        nchk++; if ({en_m, busy_m, abort_m} !== 3'b000) begin errs++; $display("FAIL reset_flags actual=%b expected=000", {en_m, busy_m, abort_m}); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int e0;
        e0 = en_cnt;
        drive(1, 0, 0);
        nchk++; if (busy_m !== 1'b1) begin errs++; $display("FAIL basic_busy actual=%b expected=1", busy_m); end
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 1, 1);
        nchk++; if (en_m !== 1'b0) begin errs++; $display("FAIL basic_early_en actual=%b expected=0", en_m); end
        drive(0, 1, 1);
        nchk++; if ({en_m, busy_m} !== 2'b10) begin errs++; $display("FAIL basic_done actual=%b expected=10", {en_m, busy_m}); end
        nchk++; if (data_m !== 4'b1011) begin errs++; $display("FAIL basic_data_m actual=%b expected=1011", data_m); end
        nchk++; if (data_l !== 4'b1101) begin errs++; $display("FAIL basic_data_l actual=%b expected=1101", data_l); end
        drive(0, 0, 0);
        drive(0, 1, 0);
        nchk++; if (en_cnt - e0 !== 1) begin errs++; $display("FAIL basic_en_pulses actual=%0d expected=1", en_cnt - e0); end
        nchk++; if (data_m !== 4'b1011) begin errs++; $display("FAIL basic_hold actual=%b expected=1011", data_m); end
        nchk++; if (q !== 4'b1011) begin errs++; $display("FAIL basic_reg_q actual=%b expected=1011", q); end
    endtask

    task automatic test_abort;
        int a0;
        a0 = abort_cnt;
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(0, 1, 1);
        drive(1, 1, 1);   // restart; start outranks bit_val
        chk1("abort_pulse", abort_m, 1'b1);
        chk1("abort_busy", busy_m, 1'b1);
        drive(0, 1, 0);
        chk1("abort_clear", abort_m, 1'b0);
        drive(0, 1, 1);
        drive(0, 1, 1);
        nchk++; if (data_m !== 4'b1011) begin errs++; $display("FAIL abort_old_held actual=%b expected=1011", data_m); end
        chk1("abort_no_early_en", en_m, 1'b0);
        drive(0, 1, 0);
        chk1("abort_done_en", en_m, 1'b1);
        nchk++; if (data_m !== 4'b0110) begin errs++; $display("FAIL abort_data_m actual=%b expected=0110", data_m); end
        nchk++; if (data_l !== 4'b0110) begin errs++; $display("FAIL abort_data_l actual=%b expected=0110", data_l); end
        drive(0, 0, 0);
        nchk++; if (abort_cnt - a0 !== 1) begin errs++; $display("FAIL abort_count actual=%0d expected=1", abort_cnt - a0); end
    endtask

    task automatic test_gaps;
        int e0;
        e0 = en_cnt;
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            chk1("gap_busy", busy_m, 1'b1);
            chk1("gap_en", en_m, 1'b0);
        end
        drive(0, 1, 1);
        drive(0, 1, 1);
        chk1("gap_done_en", en_m, 1'b1);
        nchk++; if (data_m !== 4'b1011) begin errs++; $display("FAIL gap_data_m actual=%b expected=1011", data_m); end
        nchk++; if (data_l !== 4'b1101) begin errs++; $display("FAIL gap_data_l actual=%b expected=1101", data_l); end
        drive(0, 0, 0);
        chk1("gap_en_drop", en_m, 1'b0);
        nchk++; if (en_cnt - e0 !== 1) begin errs++; $display("FAIL gap_en_pulses actual=%0d expected=1", en_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        nchk++; if ({en_m, data_m} !== 5'b1_0001) begin errs++; $display("FAIL b2b_first actual=%b expected=10001", {en_m, data_m}); end
        drive(1, 1, 0);   // start in DONE; the bit here must be ignored
        chk1("b2b_busy", busy_m, 1'b1);
        nchk++; if (q !== 4'b0001) begin errs++; $display("FAIL b2b_reg_q1 actual=%b expected=0001", q); end
        drive(0, 1, 1);
        drive(0, 1, 1);
        drive(0, 1, 1);
        chk1("b2b_no_early_en", en_m, 1'b0);
        drive(0, 1, 1);
        nchk++; if ({en_m, data_m} !== 5'b1_1111) begin errs++; $display("FAIL b2b_second actual=%b expected=11111", {en_m, data_m}); end
        drive(0, 0, 0);
        nchk++; if (en_t_last - en_t_prev !== 5) begin errs++; $display("FAIL b2b_spacing actual=%0d expected=5", en_t_last - en_t_prev); end
        nchk++; if (q !== 4'hF) begin errs++; $display("FAIL b2b_reg_q2 actual=%h expected=f", q); end
    endtask

    task automatic test_reset_midframe;
        int e0, a0;
        e0 = en_cnt;
        a0 = abort_cnt;
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 1, 1);
        reset = 1'b1;
        drive(0, 1, 1);
        reset = 1'b0;
        nchk++; if ({en_m, busy_m, abort_m, data_m} !== 7'b0) begin errs++; $display("FAIL midrst_state actual=%b expected=0000000", {en_m, busy_m, abort_m, data_m}); end
        for (int i = 0; i < 4; i++) drive(0, 1, 1);   // bit_val ignored in IDLE
        chk1("midrst_idle_busy", busy_m, 1'b0);
        nchk++; if (en_cnt - e0 !== 0) begin errs++; $display("FAIL midrst_no_en actual=%0d expected=0", en_cnt - e0); end
        nchk++; if (abort_cnt - a0 !== 0) begin errs++; $display("FAIL midrst_no_abort actual=%0d expected=0", abort_cnt - a0); end
        nchk++; if (data_m !== 4'h0) begin errs++; $display("FAIL midrst_data_held actual=%h expected=0", data_m); end
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 1, 0);
        nchk++; if ({en_m, data_m, data_l} !== 9'b1_0100_0010) begin errs++; $display("FAIL midrst_recover actual=%b expected=101000010", {en_m, data_m, data_l}); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bit_val = 1'b0; bit_in = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end

endmodule
